// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU/LSU/MDU results into one registered regs_file write, with a pending-write scoreboard and hazard stall
module wb_arbiter #(
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          issue_long_i,
  input  logic [4:0]    issue_rd_i,
  input  logic [4:0]    raddr_a_i,
  input  logic [4:0]    raddr_b_i,
  input  logic [4:0]    rd_chk_i,
  output logic          stall_o,
  output logic          issue_hold_o,
  input  logic          alu_valid_i,
  input  logic [4:0]    alu_rd_i,
  input  logic [DW-1:0] alu_wdata_i,
  input  logic          lsu_valid_i,
  output logic          lsu_ready_o,
  input  logic [4:0]    lsu_rd_i,
  input  logic [DW-1:0] lsu_wdata_i,
  input  logic          mdu_valid_i,
  output logic          mdu_ready_o,
  input  logic [4:0]    mdu_rd_i,
  input  logic [DW-1:0] mdu_wdata_i,
  output logic          we_o,
  output logic [4:0]    waddr_o,
  output logic [DW-1:0] wdata_o
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [31:0]   busy, busy_nxt;
  logic          rr_mdu;
  logic [CW-1:0] cnt;
  logic          lsu_g, mdu_g, long_g, any_g;
  assign lsu_g        = !alu_valid_i && lsu_valid_i && (!mdu_valid_i || !rr_mdu);
  assign mdu_g        = !alu_valid_i && mdu_valid_i && (!lsu_valid_i || rr_mdu);
  assign long_g       = lsu_g || mdu_g;
  assign any_g        = alu_valid_i || long_g;
  assign lsu_ready_o  = lsu_g;
  assign mdu_ready_o  = mdu_g;
  assign stall_o      = busy[raddr_a_i] || busy[raddr_b_i] || busy[rd_chk_i];
  assign issue_hold_o = cnt == CW'(STARVE_LIMIT);
  always_comb begin
    busy_nxt = busy;
    if (lsu_g) busy_nxt[lsu_rd_i] = 1'b0;
    if (mdu_g) busy_nxt[mdu_rd_i] = 1'b0;
    if (issue_long_i) busy_nxt[issue_rd_i] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy    <= '0;
      rr_mdu  <= 1'b0;
      cnt     <= '0;
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else begin
      busy   <= busy_nxt;
      rr_mdu <= lsu_g ? 1'b1 : mdu_g ? 1'b0 : rr_mdu;
      cnt    <= long_g ? '0 : ((lsu_valid_i || mdu_valid_i) && !issue_hold_o) ? cnt + CW'(1) : cnt;
      we_o   <= any_g;
      if (any_g) begin
        waddr_o <= alu_valid_i ? alu_rd_i : lsu_g ? lsu_rd_i : mdu_rd_i;
        wdata_o <= alu_valid_i ? alu_wdata_i : lsu_g ? lsu_wdata_i : mdu_wdata_i;
      end
    end
  end
  a_hold_bubble: assert property (@(posedge clk_i) disable iff (!rst_ni) issue_hold_o |=> !alu_valid_i);
  a_lsu_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lsu_valid_i && !lsu_ready_o |=> lsu_valid_i && $stable(lsu_rd_i) && $stable(lsu_wdata_i));
  a_mdu_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mdu_valid_i && !mdu_ready_o |=> mdu_valid_i && $stable(mdu_rd_i) && $stable(mdu_wdata_i));
  a_issue_free: assert property (@(posedge clk_i) disable iff (!rst_ni)
    issue_long_i |-> !busy[issue_rd_i] || (lsu_g && lsu_rd_i == issue_rd_i) || (mdu_g && mdu_rd_i == issue_rd_i));
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus checked against a behavioural write-port model every cycle
module tb_wb_arbiter;
  localparam int DW = 32;
  localparam int LIM = 4;
  logic          clk_i = 1'b0, rst_ni = 1'b0;
  logic          issue_long_i = 1'b0;
  logic [4:0]    issue_rd_i = '0, raddr_a_i = '0, raddr_b_i = '0, rd_chk_i = '0;
  logic          stall_o, issue_hold_o;
  logic          alu_valid_i = 1'b0, lsu_valid_i = 1'b0, mdu_valid_i = 1'b0;
  logic [4:0]    alu_rd_i = '0, lsu_rd_i = '0, mdu_rd_i = '0;
  logic [DW-1:0] alu_wdata_i = '0, lsu_wdata_i = '0, mdu_wdata_i = '0;
  logic          lsu_ready_o, mdu_ready_o, we_o;
  logic [4:0]    waddr_o;
  logic [DW-1:0] wdata_o;
  int tests = 0, fails = 0;
  wb_arbiter #(.DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .issue_long_i(issue_long_i), .issue_rd_i(issue_rd_i),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .rd_chk_i(rd_chk_i), .stall_o(stall_o),
    .issue_hold_o(issue_hold_o), .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i),
    .alu_wdata_i(alu_wdata_i), .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_rd_i(lsu_rd_i), .lsu_wdata_i(lsu_wdata_i), .mdu_valid_i(mdu_valid_i),
    .mdu_ready_o(mdu_ready_o), .mdu_rd_i(mdu_rd_i), .mdu_wdata_i(mdu_wdata_i),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  bit [31:0]     pend;
  int            last_long, waited;
  bit            m_we;
  logic [4:0]    m_addr;
  logic [DW-1:0] m_data;
  function automatic int winner();
    if (alu_valid_i) return 1;
    if (lsu_valid_i && mdu_valid_i) return last_long == 2 ? 3 : 2;
    return lsu_valid_i ? 2 : mdu_valid_i ? 3 : 0;
  endfunction
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend = '0; last_long = 3; waited = 0; m_we = 0; m_addr = '0; m_data = '0;
    end else begin
      automatic int w = winner();
      m_we = w != 0;
      if (w == 1) begin m_addr = alu_rd_i; m_data = alu_wdata_i; end
      if (w == 2) begin m_addr = lsu_rd_i; m_data = lsu_wdata_i; pend[lsu_rd_i] = 0; end
      if (w == 3) begin m_addr = mdu_rd_i; m_data = mdu_wdata_i; pend[mdu_rd_i] = 0; end
      if (w >= 2) begin last_long = w; waited = 0; end
      else if (lsu_valid_i || mdu_valid_i) waited = (waited + 1 > LIM) ? LIM : waited + 1;
      if (issue_long_i && issue_rd_i != 0) pend[issue_rd_i] = 1;
    end
  end
  always @(negedge clk_i) begin
    if (rst_ni) begin
      automatic int w = winner();
      chk("stall", stall_o, pend[raddr_a_i] | pend[raddr_b_i] | pend[rd_chk_i]);
      chk("hold", issue_hold_o, waited == LIM);
      chk("lsu_ready", lsu_ready_o, w == 2);
      chk("mdu_ready", mdu_ready_o, w == 3);
      chk("we", we_o, m_we);
      chk("waddr", waddr_o, m_addr);
      chk("wdata", wdata_o, m_data);
    end
  end
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    cyc(); cyc();
    rst_ni = 1'b1;
    #1;
    chk("rst_we", we_o, 0); chk("rst_stall", stall_o, 0); chk("rst_hold", issue_hold_o, 0);
    chk("rst_lsu_rdy", lsu_ready_o, 0); chk("rst_mdu_rdy", mdu_ready_o, 0);
    alu_valid_i = 1; alu_rd_i = 5; alu_wdata_i = 32'h1234;
    cyc();
    alu_valid_i = 0;
    chk("alu_we", we_o, 1); chk("alu_waddr", waddr_o, 5); chk("alu_wdata", wdata_o, 32'h1234);
    cyc();
    chk("idle_we", we_o, 0); chk("idle_waddr_hold", waddr_o, 5);
    issue_long_i = 1; issue_rd_i = 7;
    cyc();
    issue_long_i = 0; raddr_a_i = 7;
    #1 chk("sb_stall", stall_o, 1);
    lsu_valid_i = 1; lsu_rd_i = 7; lsu_wdata_i = 32'hAA;
    #1 chk("sb_lsu_rdy", lsu_ready_o, 1);
    cyc();
    lsu_valid_i = 0;
    chk("sb_we", we_o, 1); chk("sb_waddr", waddr_o, 7); chk("sb_wdata", wdata_o, 32'hAA);
    chk("sb_stall_clr", stall_o, 0);
    mdu_valid_i = 1; mdu_rd_i = 3; mdu_wdata_i = 32'h33;
    cyc();
    lsu_valid_i = 1; lsu_rd_i = 10; lsu_wdata_i = 32'h100;
    mdu_rd_i = 11; mdu_wdata_i = 32'h200;
    #1 chk("rr1_lsu", lsu_ready_o, 1); chk("rr1_mdu", mdu_ready_o, 0);
    cyc();
    chk("rr1_waddr", waddr_o, 10);
    lsu_rd_i = 12; lsu_wdata_i = 32'h300;
    #1 chk("rr2_mdu", mdu_ready_o, 1); chk("rr2_lsu", lsu_ready_o, 0);
    cyc();
    mdu_valid_i = 0;
    chk("rr2_waddr", waddr_o, 11); chk("rr2_wdata", wdata_o, 32'h200);
    cyc();
    lsu_valid_i = 0;
    chk("rr3_waddr", waddr_o, 12); chk("rr3_wdata", wdata_o, 32'h300);
    mdu_valid_i = 1; mdu_rd_i = 4; mdu_wdata_i = 32'h44;
    alu_valid_i = 1; alu_rd_i = 1;
    for (int i = 0; i < 5; i++) begin
      alu_wdata_i = 32'(i);
      #1 chk("starve_hold", issue_hold_o, i == 4);
      cyc();
    end
    alu_valid_i = 0;
    #1 chk("starve_grant", mdu_ready_o, 1);
    cyc();
    mdu_valid_i = 0;
    chk("starve_waddr", waddr_o, 4); chk("starve_wdata", wdata_o, 32'h44);
    chk("starve_hold_clr", issue_hold_o, 0);
    issue_long_i = 1; issue_rd_i = 9;
    cyc();
    raddr_a_i = 9;
    lsu_valid_i = 1; lsu_rd_i = 9; lsu_wdata_i = 32'h99;
    cyc();
    issue_long_i = 0;
    chk("corner_busy9", stall_o, 1);
    cyc();
    lsu_valid_i = 0;
    chk("corner_retire9", stall_o, 0);
    issue_long_i = 1; issue_rd_i = 0; raddr_a_i = 0; raddr_b_i = 0; rd_chk_i = 0;
    cyc();
    issue_long_i = 0;
    chk("corner_rd0", stall_o, 0);
    alu_valid_i = 1; alu_rd_i = 0; alu_wdata_i = 32'h55;
    cyc();
    alu_valid_i = 0;
    chk("alu_rd0_we", we_o, 1); chk("alu_rd0_waddr", waddr_o, 0);
    issue_long_i = 1; issue_rd_i = 20;
    cyc();
    issue_long_i = 0; rd_chk_i = 20;
    #1 chk("waw_stall", stall_o, 1);
    rst_ni = 0;
    #1 chk("arst_stall", stall_o, 0); chk("arst_we", we_o, 0); chk("arst_wdata", wdata_o, 0);
    cyc();
    rst_ni = 1;
    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
